// File: rtl/reg_xfer_seq.sv
// Register-to-register transfer sequencer that moves data through the accumulator.
// Supports MOVE, SWAP and CLEAR operations and always restores the accumulator afterwards.
module reg_xfer_seq #(
    parameter int             RAW      = 4,
    parameter logic [RAW-1:0] ACC_ADDR = 4'b1110
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           Start,
    input  logic [1:0]     Op,
    input  logic [RAW-1:0] Rs,
    input  logic [RAW-1:0] Rd,
    input  logic [7:0]     ACCRead,
    input  logic [7:0]     ReadDataOut,
    output logic [RAW-1:0] ReadAddr,
    output logic           ReadRegEn,
    output logic [RAW-1:0] RegWriteAddr,
    output logic           WriteRegEn,
    output logic           WriteACCEn,
    output logic [7:0]     ACCWrite,
    output logic           Busy,
    output logic           Done,
    output logic           Err
);

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_SWAP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        RDTMP,
        LOADA,
        STORE1,
        LOADT,
        STORE2,
        RESTORE,
        DONE,
        ERR
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [RAW-1:0] rs_q, rs_d;
    logic [RAW-1:0] rd_q, rd_d;
    logic [7:0]     save_acc_q, save_acc_d;
    logic [7:0]     tmp_q, tmp_d;
    logic           reject;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rs_q       <= '0;
            rd_q       <= '0;
            save_acc_q <= '0;
            tmp_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs_q       <= rs_d;
            rd_q       <= rd_d;
            save_acc_q <= save_acc_d;
            tmp_q      <= tmp_d;
        end
    end

    // CLEAR never reads Rs, so an accumulator source address only matters for MOVE/SWAP.
    assign reject = (Op == OP_RSVD)
                 || (((Op == OP_MOVE) || (Op == OP_SWAP)) && (Rs == ACC_ADDR))
                 || (Rd == ACC_ADDR);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs_d       = rs_q;
        rd_d       = rd_q;
        save_acc_d = save_acc_q;
        tmp_d      = tmp_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d       = Op;
                    rs_d       = Rs;
                    rd_d       = Rd;
                    save_acc_d = ACCRead;
                    if (reject)
                        state_d = ERR;
                    else if (Op == OP_SWAP)
                        state_d = RDTMP;
                    else
                        state_d = LOADA;
                end
            end
            RDTMP: begin
                tmp_d   = ReadDataOut;
                state_d = LOADA;
            end
            LOADA:   state_d = STORE1;
            STORE1:  state_d = (op_q == OP_SWAP) ? LOADT : RESTORE;
            LOADT:   state_d = STORE2;
            STORE2:  state_d = RESTORE;
            RESTORE: state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on state only (plus the read-data passthrough while loading the accumulator).
    always_comb begin
        ReadAddr     = '0;
        ReadRegEn    = 1'b0;
        RegWriteAddr = '0;
        WriteRegEn   = 1'b0;
        WriteACCEn   = 1'b0;
        ACCWrite     = 8'h00;
        Done         = 1'b0;
        Err          = 1'b0;

        case (state_q)
            RDTMP: begin
                ReadAddr  = rd_q;
                ReadRegEn = 1'b1;
            end
            LOADA: begin
                WriteACCEn = 1'b1;
                if (op_q != OP_CLEAR) begin
                    ReadAddr  = rs_q;
                    ReadRegEn = 1'b1;
                    ACCWrite  = ReadDataOut;
                end
            end
            STORE1: begin
                WriteRegEn   = 1'b1;
                RegWriteAddr = rd_q;
            end
            LOADT: begin
                WriteACCEn = 1'b1;
                ACCWrite   = tmp_q;
            end
            STORE2: begin
                WriteRegEn   = 1'b1;
                RegWriteAddr = rs_q;
            end
            RESTORE: begin
                WriteACCEn = 1'b1;
                ACCWrite   = save_acc_q;
            end
            DONE:    Done = 1'b1;
            ERR:     Err  = 1'b1;
            default: ;
        endcase
    end

    assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Directed bench for reg_xfer_seq: a behavioural register file and accumulator surround the DUT,
// expected results are queued at each request and checked when Done/Err appears.
module tb_reg_xfer_seq;

    logic       CLK;
    logic       Reset;
    logic       Start;
    logic [1:0] Op;
    logic [3:0] Rs;
    logic [3:0] Rd;
    logic [7:0] ACCRead;
    logic [7:0] ReadDataOut;
    logic [3:0] ReadAddr;
    logic       ReadRegEn;
    logic [3:0] RegWriteAddr;
    logic       WriteRegEn;
    logic       WriteACCEn;
    logic [7:0] ACCWrite;
    logic       Busy;
    logic       Done;
    logic       Err;

    reg_xfer_seq dut (
        .CLK(CLK),
        .Reset(Reset),
        .Start(Start),
        .Op(Op),
        .Rs(Rs),
        .Rd(Rd),
        .ACCRead(ACCRead),
        .ReadDataOut(ReadDataOut),
        .ReadAddr(ReadAddr),
        .ReadRegEn(ReadRegEn),
        .RegWriteAddr(RegWriteAddr),
        .WriteRegEn(WriteRegEn),
        .WriteACCEn(WriteACCEn),
        .ACCWrite(ACCWrite),
        .Busy(Busy),
        .Done(Done),
        .Err(Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment: register file and accumulator, with a preload port used only while the DUT is idle.
    logic [7:0] rf [16];
    logic [7:0] acc;
    logic       pre_en;
    logic       pre_acc;
    logic [3:0] pre_addr;
    logic [7:0] pre_data;

    assign ACCRead     = acc;
    assign ReadDataOut = rf[ReadAddr];

    always @(posedge CLK) begin
        if (pre_en) begin
            if (pre_acc) acc <= pre_data;
            else         rf[pre_addr] <= pre_data;
        end else begin
            if (WriteRegEn) rf[RegWriteAddr] <= acc;
            if (WriteACCEn) acc <= ACCWrite;
        end
    end

    int overlap_cnt = 0;
    int we_cnt      = 0;
    int quiet_viol  = 0;

    always @(negedge CLK) begin
        if (WriteRegEn && WriteACCEn) overlap_cnt++;
        if (WriteRegEn || WriteACCEn) we_cnt++;
        if (!WriteRegEn && !WriteACCEn && !ReadRegEn &&
            ((ReadAddr != 4'd0) || (RegWriteAddr != 4'd0) || (ACCWrite != 8'd0)))
            quiet_viol++;
    end

    logic [31:0] outs_vec;
    assign outs_vec = 32'({ReadAddr, ReadRegEn, RegWriteAddr, WriteRegEn, WriteACCEn,
                           ACCWrite, Busy, Done, Err});

    typedef struct {
        string      tag;
        int         lat;
        bit         is_err;
        logic [3:0] a1;
        logic [7:0] v1;
        logic [3:0] a2;
        logic [7:0] v2;
        logic [7:0] acc;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   neg_cnt    = 0;
    int   start_neg  = 0;

    task automatic tick();
        @(negedge CLK);
        neg_cnt++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setReg(input logic [3:0] a, input logic [7:0] v);
        pre_en = 1'b1; pre_acc = 1'b0; pre_addr = a; pre_data = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic setAcc(input logic [7:0] v);
        pre_en = 1'b1; pre_acc = 1'b1; pre_addr = 4'd0; pre_data = v;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic pushExpect(input string tag, input int lat, input bit is_err,
                              input logic [3:0] a1, input logic [7:0] v1,
                              input logic [3:0] a2, input logic [7:0] v2, input logic [7:0] accv);
        exp_t e;
        e.tag = tag; e.lat = lat; e.is_err = is_err;
        e.a1 = a1; e.v1 = v1; e.a2 = a2; e.v2 = v2; e.acc = accv;
        sb.push_back(e);
    endtask

    // One-cycle Start pulse; the next posedge is the Start edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] rs, input logic [3:0] rd);
        Start = 1'b1; Op = op; Rs = rs; Rd = rd;
        start_neg = neg_cnt;
        tick();
        Start = 1'b0;
    endtask

    task automatic checkResult();
        exp_t e;
        bit   seen = 1'b0;
        int   budget = 12;
        while (!seen && budget > 0) begin
            if (Done || Err) seen = 1'b1;
            else begin
                tick();
                budget--;
            end
        end
        e = sb.pop_front();
        checkOutput({e.tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({e.tag, "_latency"}, 32'(neg_cnt - start_neg), 32'(e.lat));
            checkOutput({e.tag, "_done"}, 32'(Done), 32'(!e.is_err));
            checkOutput({e.tag, "_err"}, 32'(Err), 32'(e.is_err));
            checkOutput({e.tag, "_reg1"}, 32'(rf[e.a1]), 32'(e.v1));
            checkOutput({e.tag, "_reg2"}, 32'(rf[e.a2]), 32'(e.v2));
            checkOutput({e.tag, "_acc"}, 32'(acc), 32'(e.acc));
            tick();
            checkOutput({e.tag, "_idle_after"}, outs_vec, 32'd0);
        end
    endtask

    int dones;
    int done_at;
    int we_before;

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; Rs = 4'd0; Rd = 4'd0;
        pre_en = 1'b0; pre_acc = 1'b0; pre_addr = 4'd0; pre_data = 8'd0;
        tick();
        tick();
        checkOutput("reset_outputs", outs_vec, 32'd0);
        Reset = 1'b0;
        setAcc(8'h00);
        for (int i = 0; i < 16; i++) setReg(4'(i), 8'h00);

        $display("[TB] MOVE");
        setReg(4'd3, 8'h5A);
        setAcc(8'h11);
        pushExpect("move", 4, 1'b0, 4'd7, 8'h5A, 4'd3, 8'h5A, 8'h11);
        applyStimulus(2'b00, 4'd3, 4'd7);
        checkResult();

        $display("[TB] SWAP");
        setReg(4'd2, 8'hA5);
        setReg(4'd9, 8'h3C);
        setAcc(8'hFF);
        pushExpect("swap", 7, 1'b0, 4'd2, 8'h3C, 4'd9, 8'hA5, 8'hFF);
        applyStimulus(2'b01, 4'd2, 4'd9);
        checkResult();

        $display("[TB] CLEAR");
        setReg(4'd5, 8'h77);
        setAcc(8'h42);
        pushExpect("clear", 4, 1'b0, 4'd5, 8'h00, 4'd2, 8'h3C, 8'h42);
        applyStimulus(2'b10, 4'd0, 4'd5);
        checkResult();

        $display("[TB] rejected requests");
        setReg(4'd0, 8'h66);
        we_before = we_cnt;
        pushExpect("err_rd_acc", 1, 1'b1, 4'd0, 8'h66, 4'd2, 8'h3C, 8'h42);
        applyStimulus(2'b00, 4'd0, 4'd14);
        checkResult();
        pushExpect("err_op11", 1, 1'b1, 4'd0, 8'h66, 4'd1, 8'h00, 8'h42);
        applyStimulus(2'b11, 4'd0, 4'd1);
        checkResult();
        pushExpect("err_rs_acc", 1, 1'b1, 4'd2, 8'h3C, 4'd14, 8'h00, 8'h42);
        applyStimulus(2'b00, 4'd14, 4'd2);
        checkResult();
        checkOutput("err_no_write_enable", 32'(we_cnt - we_before), 32'd0);

        $display("[TB] Start re-pulsed while busy");
        setReg(4'd3, 8'h21);
        setReg(4'd8, 8'h00);
        setAcc(8'h17);
        Start = 1'b1; Op = 2'b00; Rs = 4'd3; Rd = 4'd8;
        dones = 0; done_at = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) begin
                Op = 2'b10; Rs = 4'd0; Rd = 4'd3;
                checkOutput("repulse_busy", 32'(Busy), 32'd1);
            end
            if (i == 4) Start = 1'b0;
            if (Done) begin
                dones++;
                if (done_at == 0) done_at = i;
            end
        end
        checkOutput("repulse_done_count", 32'(dones), 32'd1);
        checkOutput("repulse_latency", 32'(done_at), 32'd4);
        checkOutput("repulse_dest", 32'(rf[8]), 32'h21);
        checkOutput("repulse_no_second_op", 32'(rf[3]), 32'h21);
        checkOutput("repulse_acc", 32'(acc), 32'h17);

        $display("[TB] reset during STORE2");
        setReg(4'd1, 8'h12);
        setReg(4'd6, 8'h34);
        setAcc(8'h99);
        applyStimulus(2'b01, 4'd1, 4'd6);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("store2_reached", 32'({WriteRegEn, RegWriteAddr}), 32'({1'b1, 4'd1}));
        Reset = 1'b1;
        tick();
        checkOutput("abort_outputs", outs_vec, 32'd0);
        checkOutput("abort_acc_holds_tmp", 32'(acc), 32'h34);
        checkOutput("abort_rd_written", 32'(rf[6]), 32'h12);
        Reset = 1'b0;
        tick();
        checkOutput("abort_stays_idle", outs_vec, 32'd0);

        $display("[TB] reset beats Start");
        Reset = 1'b1; Start = 1'b1; Op = 2'b00; Rs = 4'd3; Rd = 4'd7;
        tick();
        checkOutput("reset_priority", outs_vec, 32'd0);
        Reset = 1'b0; Start = 1'b0;
        tick();
        checkOutput("reset_priority_idle", 32'(Busy), 32'd0);

        $display("[TB] SWAP with Rs == Rd");
        setReg(4'd4, 8'h81);
        setAcc(8'h5C);
        pushExpect("swap_same", 7, 1'b0, 4'd4, 8'h81, 4'd6, 8'h12, 8'h5C);
        applyStimulus(2'b01, 4'd4, 4'd4);
        checkResult();

        tick();
        checkOutput("write_enables_exclusive", 32'(overlap_cnt), 32'd0);
        checkOutput("quiet_outputs_zero", 32'(quiet_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
